// File: rtl/magnitude_search_ctrl.sv
// rtl/magnitude_search_ctrl.sv - binary-search initiator driving an external magnitude comparator
// Optional build macro: SEARCH_FLAGCHK_EN (non-one-hot comparator flags end the search with err).
module magnitude_search_ctrl #(
    parameter int W = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   c0,
    input  logic                   c1,
    input  logic                   c2,
    output logic [W-1:0]           guess,
    output logic                   busy,
    output logic                   done,
    output logic                   found,
    output logic [W-1:0]           result,
    output logic [$clog2(W+2)-1:0] steps,
    output logic                   err
);

    localparam int SW = $clog2(W+2);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CHECK = 1'b1;

    logic [0:0]   state_q,  state_d;
    logic [W-1:0] lo_q,     lo_d;
    logic [W-1:0] hi_q,     hi_d;
    logic [W-1:0] guess_q,  guess_d;
    logic [W-1:0] result_q, result_d;
    logic [SW-1:0] steps_q, steps_d;
    logic         done_q,   done_d;
    logic         found_q,  found_d;
    logic         err_q,    err_d;

    logic [W-1:0] guess_dec;
    logic [W-1:0] guess_inc;
    logic         flags_bad;

    // Midpoint of [l, h] formed one bit wider so the sum can never wrap.
    function automatic logic [W-1:0] midpoint(input logic [W-1:0] l, input logic [W-1:0] h);
        logic [W:0] span;
        logic [W:0] sum;
        span = {1'b0, h} - {1'b0, l};
        sum  = {1'b0, l} + (span >> 1);
        return W'(sum);
    endfunction

    // Neighbours of the current probe; only consumed when the bound checks prove they cannot wrap.
    assign guess_dec = guess_q - W'(1);
    assign guess_inc = guess_q + W'(1);

`ifdef SEARCH_FLAGCHK_EN
    assign flags_bad = !$onehot({c0, c1, c2});
`else
    assign flags_bad = 1'b0;
`endif

    // Next-state logic: accept start in IDLE, narrow [lo, hi] once per probe in CHECK.
    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        guess_d  = guess_q;
        result_d = result_q;
        steps_d  = steps_q;
        found_d  = found_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lo_d     = '0;
                    hi_d     = '1;
                    guess_d  = midpoint('0, '1);
                    steps_d  = '0;
                    found_d  = 1'b0;
                    result_d = '0;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                steps_d = steps_q + SW'(1);
                if (flags_bad) begin
                    err_d    = 1'b1;
                    done_d   = 1'b1;
                    found_d  = 1'b0;
                    result_d = '0;
                    state_d  = S_IDLE;
                end else if (c1) begin
                    result_d = guess_q;
                    found_d  = 1'b1;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else if (c0) begin
                    if (guess_q == lo_q) begin
                        found_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        hi_d    = guess_dec;
                        guess_d = midpoint(lo_q, guess_dec);
                    end
                end else begin
                    // c2, or no flag at all: target lies above the probe
                    if (guess_q == hi_q) begin
                        found_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        lo_d    = guess_inc;
                        guess_d = midpoint(guess_inc, hi_q);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any search without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            guess_q  <= '0;
            result_q <= '0;
            steps_q  <= '0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            steps_q  <= steps_d;
            done_q   <= done_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    assign guess  = guess_q;
    assign busy   = (state_q == S_CHECK);
    assign done   = done_q;
    assign found  = found_q;
    assign result = result_q;
    assign steps  = steps_q;
    assign err    = err_q;

endmodule

// File: tb/tb_magnitude_search_ctrl.sv
// tb/tb_magnitude_search_ctrl.sv - randomized self-checking bench for magnitude_search_ctrl
module tb_magnitude_search_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic start2 = 1'b0;
    logic start4 = 1'b0;
    logic force2 = 1'b0;
    int   tgt2 = 0;
    int   tgt4 = 0;

    logic [1:0] guess2, result2, steps2;
    logic       busy2, done2, found2, err2;
    logic       c0_2, c1_2, c2_2;
    logic [3:0] guess4, result4;
    logic [2:0] steps4;
    logic       busy4, done4, found4, err4;
    logic       c0_4, c1_4, c2_4;

    // comparator models; force2 drives an inconsistent c0=c2=1 pattern
    assign c0_2 = force2 ? 1'b1 : (int'(guess2) > tgt2);
    assign c1_2 = force2 ? 1'b0 : (int'(guess2) == tgt2);
    assign c2_2 = force2 ? 1'b1 : (int'(guess2) < tgt2);
    assign c0_4 = (int'(guess4) > tgt4);
    assign c1_4 = (int'(guess4) == tgt4);
    assign c2_4 = (int'(guess4) < tgt4);

    magnitude_search_ctrl #(.W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .c0(c0_2), .c1(c1_2), .c2(c2_2),
        .guess(guess2), .busy(busy2), .done(done2), .found(found2), .result(result2),
        .steps(steps2), .err(err2)
    );

    magnitude_search_ctrl #(.W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .c0(c0_4), .c1(c1_4), .c2(c2_4),
        .guess(guess4), .busy(busy4), .done(done4), .found(found4), .result(result4),
        .steps(steps4), .err(err4)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt2 = 0;
    int exp_q[$];
    int order[16];

    always @(negedge clk) if (done2) done_cnt2++;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference: plain binary search over integers; fills exp_q with probes, returns probe count.
    function automatic int model(input int w, input int tgt);
        int lo, hi, g, n;
        lo = 0;
        hi = (1 << w) - 1;
        n  = 0;
        exp_q.delete();
        while (1) begin
            g = (lo + hi) / 2;
            exp_q.push_back(g);
            n++;
            if (g == tgt) break;
            if (g > tgt) begin
                if (g == lo) break;
                hi = g - 1;
            end else begin
                if (g == hi) break;
                lo = g + 1;
            end
        end
        return n;
    endfunction

    task automatic search2(input int tgt, input bit repulse);
        int ns, k, base;
        tgt2 = tgt;
        ns   = model(2, tgt);
        base = done_cnt2;
        k    = 0;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        while (!done2 && k < 8) begin
            check("busy2", 32'(busy2), 1);
            if (k < exp_q.size()) check("guess2", 32'(guess2), exp_q[k]);
            if (repulse && k == 0) start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            k++;
        end
        check("done2", 32'(done2), 1);
        check("steps2", 32'(steps2), ns);
        check("found2", 32'(found2), 1);
        check("result2", 32'(result2), tgt);
        check("err2", 32'(err2), 0);
        check("busy2_after", 32'(busy2), 0);
        @(negedge clk);
        check("done2_pulse", 32'(done2), 0);
        check("result2_hold", 32'(result2), tgt);
        check("done2_count", done_cnt2 - base, 1);
    endtask

    task automatic search4(input int tgt);
        int ns, k;
        tgt4 = tgt;
        ns   = model(4, tgt);
        k    = 0;
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        while (!done4 && k < 12) begin
            if (k < exp_q.size()) check("guess4", 32'(guess4), exp_q[k]);
            @(negedge clk);
            k++;
        end
        check("done4", 32'(done4), 1);
        check("found4", 32'(found4), 1);
        check("result4", 32'(result4), tgt);
        check("steps4", 32'(steps4), ns);
        check("steps4_max", int'(steps4 <= 3'd5), 1);
        check("busy4_after", 32'(busy4), 0);
        check("err4", 32'(err4), 0);
    endtask

    initial begin
        int base;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_guess", 32'(guess2), 0);
        check("rst_busy", 32'(busy2), 0);
        check("rst_done", 32'(done2), 0);
        check("rst_found", 32'(found2), 0);
        check("rst_result", 32'(result2), 0);
        check("rst_steps", 32'(steps2), 0);
        check("rst_err", 32'(err2), 0);
        check("rst_busy4", 32'(busy4), 0);
        rst_n = 1'b1;
        @(negedge clk);

        search2(3, 1'b0);
        search2(0, 1'b0);
        search2(1, 1'b0);
        search2(2, 1'b1);

        for (int i = 0; i < 16; i++) order[i] = i;
        for (int i = 15; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(0, i));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 16; i++) begin
            search4(order[i]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (6) search2(int'($urandom_range(0, 3)), 1'b0);

        // reset one cycle after the first probe is presented
        tgt2 = 3;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        check("pre_rst_busy", 32'(busy2), 1);
        check("pre_rst_guess", 32'(guess2), 1);
        base = done_cnt2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_guess", 32'(guess2), 0);
        check("mid_rst_busy", 32'(busy2), 0);
        check("mid_rst_steps", 32'(steps2), 0);
        check("mid_rst_result", 32'(result2), 0);
        check("mid_rst_found", 32'(found2), 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(busy2), 0);
        check("post_rst_done", 32'(done2), 0);
        check("post_rst_nodone", done_cnt2 - base, 0);
        search2(3, 1'b0);

`ifdef SEARCH_FLAGCHK_EN
        force2 = 1'b1;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        @(negedge clk);
        check("fc_done", 32'(done2), 1);
        check("fc_err", 32'(err2), 1);
        check("fc_found", 32'(found2), 0);
        check("fc_steps", 32'(steps2), 1);
        check("fc_result", 32'(result2), 0);
        force2 = 1'b0;
        @(negedge clk);
        check("fc_err_pulse", 32'(err2), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
